// File: rtl/rstatus_writeback.sv
// Buffers rstatus overflow codes in a small FIFO and commits them to the status
// register through idle cycles of the shared register-file write port.
module rstatus_writeback #(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned COUNT_W    = 8,
    parameter int unsigned STATUS_REG = 30
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ovf_valid,
    input  logic [31:0]        rstatus_in,
    input  logic               wb_busy,
    input  logic               clr_sticky,
    output logic               wb_we,
    output logic [4:0]         wb_reg,
    output logic [31:0]        wb_data,
    output logic [4:0]         last_class,
    output logic [COUNT_W-1:0] exc_count,
    output logic               lost,
    output logic               bad_code,
    output logic               irq
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    // Legal codes fit in three bits, so only those are stored.
    logic [2:0]         mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]   occ_q, occ_d;
    logic [4:0]         last_class_q, last_class_d;
    logic [COUNT_W-1:0] exc_count_q, exc_count_d;
    logic               lost_q, lost_d, bad_code_q, bad_code_d;

    logic               empty, full, legal, pop, push, drop;
    logic [2:0]         head;
    logic [4:0]         head_class;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == OCC_W'(DEPTH));
    assign legal = (rstatus_in[31:3] == '0) && (rstatus_in[2:0] >= 3'd1) && (rstatus_in[2:0] <= 3'd5);
    assign pop   = !empty && !wb_busy;
    // When full, a same-edge pop frees the slot the push lands in.
    assign push  = ovf_valid && legal && (!full || pop);
    assign drop  = ovf_valid && legal && full && !pop;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        head_class = '0;
        case (head)
            3'd1:    head_class = 5'b00001;
            3'd2:    head_class = 5'b00010;
            3'd3:    head_class = 5'b00100;
            3'd4:    head_class = 5'b01000;
            3'd5:    head_class = 5'b10000;
            default: head_class = '0;
        endcase
    end

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        occ_d        = occ_q;
        last_class_d = last_class_q;
        exc_count_d  = exc_count_q;
        lost_d       = lost_q | drop;
        bad_code_d   = bad_code_q | (ovf_valid && !legal);
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            last_class_d = head_class;
            if (exc_count_q != '1) begin
                exc_count_d = exc_count_q + COUNT_W'(1);
            end
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
        if (clr_sticky) begin
            lost_d      = 1'b0;
            bad_code_d  = 1'b0;
            exc_count_d = '0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            occ_q        <= '0;
            last_class_q <= '0;
            exc_count_q  <= '0;
            lost_q       <= 1'b0;
            bad_code_q   <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            occ_q        <= occ_d;
            last_class_q <= last_class_d;
            exc_count_q  <= exc_count_d;
            lost_q       <= lost_d;
            bad_code_q   <= bad_code_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rstatus_in[2:0];
        end
    end

    assign wb_we      = pop;
    assign wb_reg     = 5'(STATUS_REG);
    assign wb_data    = pop ? {29'd0, head} : '0;
    assign last_class = last_class_q;
    assign exc_count  = exc_count_q;
    assign lost       = lost_q;
    assign bad_code   = bad_code_q;
    assign irq        = !empty || lost_q || bad_code_q;
endmodule
